// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART blocks.
//   tx_state_e    : transmitter FSM states
//   PARITY_*      : encoding of the PARITY parameter (0 none, 1 even, 2 odd)
//   DIV_W         : width of the baud divider (clock cycles per bit)
//   effective_div : maps a raw divider onto cycles per bit (0 and 1 both mean 1)
package uart_pkg;

  localparam int DIV_W = 14;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // A divider of 0 would otherwise underflow the down-counter reload, so it
  // is treated the same as 1.
  function automatic logic [DIV_W-1:0] effective_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with extra-MSB pointers. Writes that arrive while full and
// reads that arrive while empty are ignored, so callers may drive push/pop
// without guarding them.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write data_i at the tail
//   data_i  : write data
//   pop_i   : drop the head entry
//   data_o  : current head entry (valid when empty_o is low)
//   full_o  : no room for another entry
//   empty_o : no entries stored
//   level_o : number of entries stored, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal low bits with differing wrap bits means the writer is a full lap
  // ahead of the reader.
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);
  assign level_o = wr_ptr - rd_ptr;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; a simultaneous push and pop move both and keep the level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8-bit UART transmitter. Bytes are queued through a valid/ready
// handshake and sent as start bit, 8 data bits LSB first, optional parity
// and STOP_BITS stop bits. Frames in the queue are sent back to back.
//   clk_i     : system clock, rising edge
//   rst_i     : asynchronous active-high reset
//   divider_i : clock cycles per bit, sampled at each frame start
//   data_i    : byte to queue
//   valid_i   : data_i is valid; accepted when ready_o is high
//   ready_o   : queue has room
//   tx_o      : registered serial line, idle high
//   busy_o    : queue non-empty or a frame in progress
//   level_o   : queue occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DIV_W-1:0]       divider_i,
  input  logic [7:0]             data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);

  // Value stop_cnt holds during the final stop period.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e        state;
  logic [DIV_W-1:0] latched_div;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] start_div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             next_parity;
  logic             stop_cnt;

  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             bit_done;
  logic             frame_end;
  logic             pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ready_o = !fifo_full;
  assign busy_o  = (state != TX_IDLE) || !fifo_empty;

  assign bit_done  = (baud_cnt == '0);
  assign frame_end = (state == TX_STOP) && bit_done && (stop_cnt == STOP_LAST);

  // A new frame starts from idle, or straight out of the last stop period so
  // queued bytes leave with no gap. Starting a frame is the only pop.
  assign pop = !fifo_empty && ((state == TX_IDLE) || frame_end);

  assign start_div   = effective_div(divider_i);
  assign next_parity = (PARITY == PARITY_ODD) ? ~^fifo_data : ^fifo_data;

  // Frame sequencer. Every bit lasts latched_div cycles: the baud counter is
  // reloaded with latched_div-1 as a bit begins and the bit ends at zero.
  // tx_o is updated on the same edge the FSM enters a state, so the line
  // always shows the bit of the current state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= TX_IDLE;
      tx_o        <= 1'b1;
      latched_div <= DIV_W'(1);
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      stop_cnt    <= 1'b0;
    end else if (pop) begin
      state       <= TX_START;
      tx_o        <= 1'b0;
      latched_div <= start_div;
      baud_cnt    <= start_div - DIV_W'(1);
      shift_reg   <= fifo_data;
      parity_bit  <= next_parity;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
    end else begin
      if (state != TX_IDLE) begin
        baud_cnt <= bit_done ? (latched_div - DIV_W'(1)) : (baud_cnt - DIV_W'(1));
      end
      case (state)
        TX_IDLE: begin
          tx_o <= 1'b1;
        end
        TX_START: begin
          if (bit_done) begin
            state     <= TX_DATA;
            tx_o      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= '0;
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            if (bit_cnt == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                state <= TX_PARITY;
                tx_o  <= parity_bit;
              end else begin
                state    <= TX_STOP;
                tx_o     <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              tx_o      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        TX_PARITY: begin
          if (bit_done) begin
            state    <= TX_STOP;
            tx_o     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            if (stop_cnt == STOP_LAST) begin
              state <= TX_IDLE;
              tx_o  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Bench for uart_tx_buffered. Instance dut uses the default configuration
// and is compared every cycle against a queue-based model of the line; dut_p
// uses odd parity with two stop bits and is checked against a literal frame.
module tb_uart_tx_buffered;

  localparam int DEPTH_A  = 4;
  localparam int STOP_A   = 1;
  localparam int PARITY_A = 0;

  logic        clk;
  logic        rst;
  logic [13:0] divider;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        tx;
  logic        busy;
  logic [2:0]  level;

  logic [13:0] dividerB;
  logic [7:0]  dataB;
  logic        validB;
  logic        readyB;
  logic        txB;
  logic        busyB;
  logic [2:0]  levelB;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Model state: bytes waiting in the queue, and the per-cycle line values of
  // the frame currently being sent that have not been shown yet.
  logic [7:0] mFifo[$];
  logic       mWave[$];
  logic       mTx = 1'b1;
  bit         mInFrame = 0;
  bit         mPush;
  bit         mPop;

  uart_tx_buffered #(
    .DEPTH     (DEPTH_A),
    .STOP_BITS (STOP_A),
    .PARITY    (PARITY_A)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .divider_i (divider),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .tx_o      (tx),
    .busy_o    (busy),
    .level_o   (level)
  );

  uart_tx_buffered #(
    .DEPTH     (4),
    .STOP_BITS (2),
    .PARITY    (2)
  ) dut_p (
    .clk_i     (clk),
    .rst_i     (rst),
    .divider_i (dividerB),
    .data_i    (dataB),
    .valid_i   (validB),
    .ready_o   (readyB),
    .tx_o      (txB),
    .busy_o    (busyB),
    .level_o   (levelB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expands one byte into the line values of its whole frame.
  function automatic void appendFrame(input logic [7:0] d, input logic [13:0] div);
    int   eff;
    logic bits[$];
    eff = (div == 14'd0) ? 1 : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PARITY_A != 0) bits.push_back((PARITY_A == 2) ? ~^d : ^d);
    for (int i = 0; i < STOP_A; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < eff; c++) mWave.push_back(bits[i]);
    end
  endfunction

  // Model step: a byte leaves the queue when the previous frame has been fully
  // shown; a byte enters when the queue had room before this edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mFifo.delete();
      mWave.delete();
      mTx      = 1'b1;
      mInFrame = 0;
    end else begin
      mPush = valid && (mFifo.size() < DEPTH_A);
      mPop  = (mWave.size() == 0) && (mFifo.size() > 0);
      if (mPop) appendFrame(mFifo.pop_front(), divider);
      if (mWave.size() > 0) begin
        mTx      = mWave.pop_front();
        mInFrame = 1;
      end else begin
        mTx      = 1'b1;
        mInFrame = 0;
      end
      if (mPush) mFifo.push_back(data);
    end
  end

  task automatic expectBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectLevel(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    expectBit("model tx", tx, mTx);
    expectBit("model ready", ready, mFifo.size() < DEPTH_A);
    expectBit("model busy", busy, mInFrame || (mFifo.size() > 0));
    expectLevel("model level", level, 3'(mFifo.size()));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && checkEn) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [13:0] div);
    @(negedge clk);
    valid   = v;
    data    = d;
    divider = div;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle timeout: busy %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Pushes one byte into an idle dut and compares every cycle of the frame
  // with a literal bit pattern (bit k of bits is frame bit k). When changeAt
  // is reached the divider input is changed mid-frame.
  task automatic sendAndCapture(input logic [7:0] d, input logic [13:0] div,
                                input logic [9:0] bits, input int cycPerBit,
                                input int changeAt, input logic [13:0] newDiv);
    applyStimulus(1'b1, d, div);
    applyStimulus(1'b0, d, div);
    expectBit("busy after push", busy, 1'b1);
    expectBit("tx before start", tx, 1'b1);
    for (int k = 0; k < 10 * cycPerBit; k++) begin
      @(posedge clk);
      #1;
      expectBit("frame tx", tx, bits[k / cycPerBit]);
      if (k == changeAt) divider = newDiv;
    end
    @(posedge clk);
    #1;
    expectBit("busy at frame end", busy, 1'b0);
    expectBit("tx after frame", tx, 1'b1);
  endtask

  task automatic burstFill();
    int  idx;
    int  guard;
    bit  willPush;
    idx   = 0;
    guard = 0;
    applyStimulus(1'b1, 8'h00, 14'd2);
    while (idx < 6 && guard < 200) begin
      willPush = ready;
      @(negedge clk);
      guard++;
      if (willPush) begin
        idx++;
        // The first byte leaves for the shifter one edge after it arrives,
        // so the queue is full after the fifth accepted byte.
        if (idx == 5) expectBit("ready at full", ready, 1'b0);
        if (idx < 6) data = 8'(idx);
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("[TB] FAIL burst accepted: got %0d bytes expected 6", idx);
    end
    waitIdle(400);
  endtask

  task automatic parityFrame();
    logic [11:0] bitsP;
    // 0x07 odd parity, two stop bits: 0,1,1,1,0,0,0,0,0,0(parity),1,1
    bitsP = 12'b110000001110;
    @(negedge clk);
    dividerB = 14'd3;
    dataB    = 8'h07;
    validB   = 1'b1;
    @(negedge clk);
    validB = 1'b0;
    expectBit("parity dut busy", busyB, 1'b1);
    for (int k = 0; k < 36; k++) begin
      @(posedge clk);
      #1;
      expectBit("parity frame tx", txB, bitsP[k / 3]);
    end
    @(posedge clk);
    #1;
    expectBit("parity dut busy end", busyB, 1'b0);
    expectBit("parity dut tx end", txB, 1'b1);
  endtask

  task automatic resetMidFrame();
    applyStimulus(1'b1, 8'h00, 14'd4);
    applyStimulus(1'b1, 8'h11, 14'd4);
    applyStimulus(1'b1, 8'h22, 14'd4);
    applyStimulus(1'b0, 8'h00, 14'd4);
    repeat (5) @(negedge clk);
    expectBit("tx in data bit", tx, 1'b0);
    expectLevel("level before reset", level, 3'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expectBit("tx async reset", tx, 1'b1);
    expectLevel("level async reset", level, 3'd0);
    expectBit("busy async reset", busy, 1'b0);
    expectBit("ready async reset", ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    expectBit("tx after reset release", tx, 1'b1);
    expectBit("busy after reset release", busy, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    divider  = 14'd4;
    validB   = 1'b0;
    dataB    = 8'h00;
    dividerB = 14'd3;
    repeat (3) @(negedge clk);
    expectBit("reset tx", tx, 1'b1);
    expectBit("reset ready", ready, 1'b1);
    expectBit("reset busy", busy, 1'b0);
    expectLevel("reset level", level, 3'd0);
    expectBit("reset parity dut tx", txB, 1'b1);
    expectBit("reset parity dut ready", readyB, 1'b1);
    expectLevel("reset parity dut level", levelB, 3'd0);
    rst     = 1'b0;
    checkEn = 1;
    @(negedge clk);

    $display("[TB] single byte 0xA5, divider 4");
    sendAndCapture(8'hA5, 14'd4, 10'b1101001010, 4, -1, 14'd4);

    $display("[TB] divider 0 and 1, then divider change mid-frame");
    sendAndCapture(8'h81, 14'd0, 10'b1100000010, 1, -1, 14'd0);
    sendAndCapture(8'h81, 14'd1, 10'b1100000010, 1, 2, 14'd7);

    $display("[TB] burst of six bytes, divider 2");
    burstFill();

    $display("[TB] odd parity, two stop bits");
    parityFrame();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 14'($urandom_range(0, 3)));
    end
    applyStimulus(1'b0, 8'h00, 14'd1);
    waitIdle(1000);

    $display("[TB] reset during a frame");
    resetMidFrame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
